// File: rtl/key_event_sync.sv
// key_event_sync: synchronise, debounce and auto-repeat push-buttons, reporting frame-stable events.
module key_event_sync #(
    parameter int N_KEYS              = 3,
    parameter bit KEYS_ACTIVE_LOW     = 1'b1,
    parameter int DEBOUNCE_CYCLES     = 200000,
    parameter int REPEAT_DELAY_FRAMES = 20,
    parameter int REPEAT_RATE_FRAMES  = 6
) (
    input  logic              i_clk_pix,
    input  logic              i_rst,
    input  logic [N_KEYS-1:0] i_key,
    input  logic              i_frame,
    output logic [N_KEYS-1:0] o_held,
    output logic [N_KEYS-1:0] o_press,
    output logic [N_KEYS-1:0] o_release,
    output logic [N_KEYS-1:0] o_repeat
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);
    localparam logic [7:0] DELAY = 8'(REPEAT_DELAY_FRAMES);
    localparam logic [7:0] RATE = 8'(REPEAT_RATE_FRAMES);

    typedef enum logic [1:0] {UP, PEND_DN, DOWN, PEND_UP} state_t;

    logic [N_KEYS-1:0] press_ev, release_ev, repeat_ev, held_nx;
    logic [N_KEYS-1:0] pend_press, pend_release, pend_repeat;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        logic [1:0] sync;
        logic raw, press, rel, rpt;
        state_t state, state_nx;
        logic [CW-1:0] cnt, cnt_nx;
        logic [7:0] rep, rep_nx;

        // Synchroniser resets to the released pin level so reset never fakes a press.
        always_ff @(posedge i_clk_pix) begin
            if (i_rst) sync <= {2{KEYS_ACTIVE_LOW}};
            else sync <= {sync[0], i_key[k]};
        end
        assign raw = sync[1] ^ KEYS_ACTIVE_LOW;

        always_ff @(posedge i_clk_pix) begin
            if (i_rst) begin
                state <= UP;
                cnt   <= '0;
                rep   <= '0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
                rep   <= rep_nx;
            end
        end

        // The cycle leaving UP/DOWN is the first agreeing sample, hence the DEBOUNCE_CYCLES-2 terminal count.
        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            rep_nx   = rep;
            press    = 1'b0;
            rel      = 1'b0;
            rpt      = 1'b0;
            case (state)
                UP: if (raw) begin
                    state_nx = PEND_DN;
                    cnt_nx   = '0;
                end
                PEND_DN: if (!raw) state_nx = UP;
                    else if (cnt == CNT_LAST) begin
                        state_nx = DOWN;
                        press    = 1'b1;
                        rep_nx   = DELAY;
                    end else cnt_nx = cnt + CW'(1);
                DOWN: begin
                    if (!raw) begin
                        state_nx = PEND_UP;
                        cnt_nx   = '0;
                    end
                    if (i_frame && rep != 8'd0) begin
                        rpt    = rep == 8'd1;
                        rep_nx = rep == 8'd1 ? RATE : rep - 8'd1;
                    end
                end
                PEND_UP: if (raw) state_nx = DOWN;
                    else if (cnt == CNT_LAST) begin
                        state_nx = UP;
                        rel      = 1'b1;
                    end else cnt_nx = cnt + CW'(1);
                default: state_nx = UP;
            endcase
        end

        assign press_ev[k]   = press;
        assign release_ev[k] = rel;
        assign repeat_ev[k]  = rpt;
        assign held_nx[k]    = state_nx == DOWN || state_nx == PEND_UP;
    end

    always_ff @(posedge i_clk_pix) begin
        if (i_rst) begin
            o_held       <= '0;
            o_press      <= '0;
            o_release    <= '0;
            o_repeat     <= '0;
            pend_press   <= '0;
            pend_release <= '0;
            pend_repeat  <= '0;
        end else if (i_frame) begin
            o_held       <= held_nx;
            o_press      <= pend_press | press_ev;
            o_release    <= pend_release | release_ev;
            o_repeat     <= pend_repeat | repeat_ev;
            pend_press   <= '0;
            pend_release <= '0;
            pend_repeat  <= '0;
        end else begin
            pend_press   <= pend_press | press_ev;
            pend_release <= pend_release | release_ev;
            pend_repeat  <= pend_repeat | repeat_ev;
        end
    end
endmodule

// File: tb/tb_key_event_sync.sv
// tb_key_event_sync: directed scoreboard bench for key_event_sync with short debounce/repeat settings.
module tb_key_event_sync;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] key;
    logic frm;
    logic [2:0] held, press, rel, rpt;
    logic [2:0] held2, press2, rel2, rpt2;
    int vecs = 0;
    int errs = 0;

    typedef struct {
        string      tag;
        logic [2:0] h, p, r, q;
        bit         c2;
        logic [2:0] q2;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    key_event_sync #(.N_KEYS(3), .KEYS_ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4),
                     .REPEAT_DELAY_FRAMES(3), .REPEAT_RATE_FRAMES(2)) dut (
        .i_clk_pix(clk), .i_rst(rst), .i_key(key), .i_frame(frm),
        .o_held(held), .o_press(press), .o_release(rel), .o_repeat(rpt));

    key_event_sync #(.N_KEYS(3), .KEYS_ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4),
                     .REPEAT_DELAY_FRAMES(3), .REPEAT_RATE_FRAMES(0)) dut_norate (
        .i_clk_pix(clk), .i_rst(rst), .i_key(key), .i_frame(frm),
        .o_held(held2), .o_press(press2), .o_release(rel2), .o_repeat(rpt2));

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] h, p, r, q,
                              input bit c2 = 1'b0, input logic [2:0] q2 = 3'b000);
        exp_t e;
        e.tag = tag;
        e.h = h;
        e.p = p;
        e.r = r;
        e.q = q;
        e.c2 = c2;
        e.q2 = q2;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            vecs++;
            errs++;
            $error("FAIL scoreboard_empty: got 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        vecs++;
        assert (held === e.h) else begin errs++; $error("FAIL %s held: got %b expected %b", e.tag, held, e.h); end
        vecs++;
        assert (press === e.p) else begin errs++; $error("FAIL %s press: got %b expected %b", e.tag, press, e.p); end
        vecs++;
        assert (rel === e.r) else begin errs++; $error("FAIL %s release: got %b expected %b", e.tag, rel, e.r); end
        vecs++;
        assert (rpt === e.q) else begin errs++; $error("FAIL %s repeat: got %b expected %b", e.tag, rpt, e.q); end
        if (e.c2) begin
            vecs++;
            assert (rpt2 === e.q2) else begin errs++; $error("FAIL %s repeat_rate0: got %b expected %b", e.tag, rpt2, e.q2); end
        end
    endtask

    task automatic frame();
        frm = 1'b1;
        step();
        frm = 1'b0;
        compare();
    endtask

    initial begin
        rst = 1'b1;
        key = 3'b000;
        frm = 1'b0;
        step(5);
        expect_out("reset_hold", 3'b000, 3'b000, 3'b000, 3'b000);
        compare();
        rst = 1'b0;
        step();
        expect_out("after_deassert", 3'b000, 3'b000, 3'b000, 3'b000);
        compare();
        step(2);
        expect_out("frame1_early", 3'b000, 3'b000, 3'b000, 3'b000);
        frame();
        step(10);
        expect_out("no_frame_10", 3'b000, 3'b000, 3'b000, 3'b000);
        compare();
        step(10);
        expect_out("no_frame_20", 3'b000, 3'b000, 3'b000, 3'b000);
        compare();
        expect_out("held_from_reset", 3'b111, 3'b111, 3'b000, 3'b000);
        frame();
        key = 3'b111;
        step(10);
        expect_out("release_all", 3'b000, 3'b000, 3'b111, 3'b000);
        frame();
        step(40);
        expect_out("idle", 3'b000, 3'b000, 3'b000, 3'b000);
        frame();

        key = 3'b110;
        step(10);
        expect_out("clean_press", 3'b001, 3'b001, 3'b000, 3'b000);
        frame();
        step(49);
        expect_out("clean_hold", 3'b001, 3'b000, 3'b000, 3'b000);
        frame();
        key = 3'b111;
        step(10);
        expect_out("clean_release", 3'b000, 3'b000, 3'b001, 3'b000);
        frame();

        for (int i = 0; i < 10; i++) begin
            key = 3'b101;
            step(3);
            key = 3'b111;
            step();
        end
        step(5);
        expect_out("bounce_reject", 3'b000, 3'b000, 3'b000, 3'b000);
        frame();
        key = 3'b101;
        step(10);
        expect_out("bounce_then_stable", 3'b010, 3'b010, 3'b000, 3'b000);
        frame();
        key = 3'b111;
        step(10);
        expect_out("bounce_release", 3'b000, 3'b000, 3'b010, 3'b000);
        frame();

        key = 3'b011;
        step(10);
        for (int k = 1; k <= 12; k++) begin
            expect_out($sformatf("repeat_f%0d", k), 3'b100, (k == 1) ? 3'b100 : 3'b000, 3'b000,
                       (k inside {3, 5, 7, 9, 11}) ? 3'b100 : 3'b000, 1'b1,
                       (k == 3) ? 3'b100 : 3'b000);
            frame();
            step(49);
        end
        key = 3'b111;
        step(10);
        expect_out("repeat_release", 3'b000, 3'b000, 3'b100, 3'b000, 1'b1, 3'b000);
        frame();

        key = 3'b110;
        step(8);
        key = 3'b111;
        step(10);
        expect_out("same_frame_pr", 3'b000, 3'b001, 3'b001, 3'b000);
        frame();
        step(49);
        expect_out("same_frame_after", 3'b000, 3'b000, 3'b000, 3'b000);
        frame();

        key = 3'b101;
        step(10);
        expect_out("midhold_press", 3'b010, 3'b010, 3'b000, 3'b000);
        frame();
        step(49);
        expect_out("midhold_hold", 3'b010, 3'b000, 3'b000, 3'b000);
        frame();
        rst = 1'b1;
        step();
        expect_out("midhold_reset", 3'b000, 3'b000, 3'b000, 3'b000);
        compare();
        step(2);
        rst = 1'b0;
        step(3);
        expect_out("midhold_no_release", 3'b000, 3'b000, 3'b000, 3'b000);
        frame();
        step(10);
        expect_out("midhold_repress", 3'b010, 3'b010, 3'b000, 3'b000);
        frame();
        key = 3'b111;
        step(10);
        expect_out("midhold_release", 3'b000, 3'b000, 3'b010, 3'b000);
        frame();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
